alu_writeback_stage: RTL and testbench

- Sits directly downstream of the 8-bit ALU.
- Registers each ALU result with its destination register address and a per-operation flag-update mask.
- Buffers results in a small in-order FIFO with valid/ready handshakes on both sides, and drives the register-file write port.
- Holds the architected status register (C, V, N, Z), updated only when a result retires to the register file.

---
 rtl/alu_writeback_stage_pkg.sv | 37 +++
 rtl/alu_writeback_stage_wb_fifo.sv | 54 +++++
 rtl/alu_writeback_stage.sv | 83 ++++++++
 tb/tb_alu_writeback_stage.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/alu_writeback_stage_pkg.sv
// Shared types and constants for the ALU write-back stage.
// Flag bit positions, flag-mask encodings and the buffered entry record.
package alu_writeback_stage_pkg;

   localparam int FLAG_C = 3;
   localparam int FLAG_V = 2;
   localparam int FLAG_N = 1;
   localparam int FLAG_Z = 0;

   localparam int ENTRY_DATA_W = 8;
   localparam int ENTRY_ADDR_W = 3;

   typedef logic [3:0] flag_mask_t;

   localparam flag_mask_t FMASK_ALL  = 4'hF;
   localparam flag_mask_t FMASK_NZ   = 4'h3;
   localparam flag_mask_t FMASK_NONE = 4'h0;

   typedef struct packed {
      logic [ENTRY_DATA_W-1:0] data;
      logic                    c;
      logic                    v;
      logic                    n;
      logic                    z;
      logic [ENTRY_ADDR_W-1:0] addr;
      logic                    wen;
      flag_mask_t              fmask;
   } wb_entry_t;

   // Bits selected by mask take the new value, the rest keep the old one.
   function automatic flag_mask_t merge_flags(input flag_mask_t old_flags,
                                              input flag_mask_t new_flags,
                                              input flag_mask_t mask);
      return (old_flags & ~mask) | (new_flags & mask);
   endfunction

endpackage

// File: rtl/alu_writeback_stage_wb_fifo.sv
// Generic in-order synchronous FIFO; full/empty derived from the occupancy count.
// Head data is read straight from registered storage at the read pointer.
module wb_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             wdata,
   output logic [W-1:0]             rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/alu_writeback_stage.sv
// Buffers ALU results ahead of the register-file write port and retires
// them in order, updating the architected C/V/N/Z status register on retire.
module alu_writeback_stage
   import alu_writeback_stage_pkg::*;
#(
   parameter int DATA_W = ENTRY_DATA_W,
   parameter int ADDR_W = ENTRY_ADDR_W,
   parameter int DEPTH  = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_W-1:0]        in_y,
   input  logic                     in_c,
   input  logic                     in_v,
   input  logic                     in_n,
   input  logic                     in_z,
   input  logic [ADDR_W-1:0]        in_addr,
   input  logic                     in_wen,
   input  logic [3:0]               in_fmask,
   output logic                     wb_valid,
   input  logic                     wb_ready,
   output logic                     wb_we,
   output logic [ADDR_W-1:0]        wb_addr,
   output logic [DATA_W-1:0]        wb_data,
   output logic [3:0]               flags,
   output logic [$clog2(DEPTH):0]   count
);

   wb_entry_t  in_entry;
   wb_entry_t  head;
   flag_mask_t head_flags;
   logic       push;
   logic       pop;
   logic       full;
   logic       empty;

   assign in_entry = '{data: in_y, c: in_c, v: in_v, n: in_n, z: in_z,
                       addr: in_addr, wen: in_wen, fmask: in_fmask};

   // Handshakes: a transfer happens on a side exactly when its valid and ready
   // are both high at the rising edge; in_ready depends only on occupancy,
   // never on wb_ready, so no combinational path runs between the two sides.
   assign in_ready = ~full;
   assign wb_valid = ~empty;
   assign push     = in_valid & in_ready;
   assign pop      = wb_valid & wb_ready;

   wb_fifo #(
      .DEPTH (DEPTH),
      .W     ($bits(wb_entry_t))
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .wdata (in_entry),
      .rdata (head),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   assign wb_addr = head.addr;
   assign wb_data = head.data;
   assign wb_we   = pop & head.wen;

   always_comb begin
      head_flags         = '0;
      head_flags[FLAG_C] = head.c;
      head_flags[FLAG_V] = head.v;
      head_flags[FLAG_N] = head.n;
      head_flags[FLAG_Z] = head.z;
   end

   // The status register only changes when an entry retires.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) flags <= '0;
      else if (pop) flags <= merge_flags(flags, head_flags, head.fmask);
   end

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Directed bench for alu_writeback_stage: vector table plus hand-written
// sequences for pointer wrap and asynchronous reset mid-operation.
module tb_alu_writeback_stage;
   import alu_writeback_stage_pkg::*;

   localparam int DEPTH = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_y = '0;
   logic       in_c = 1'b0, in_v = 1'b0, in_n = 1'b0, in_z = 1'b0;
   logic [2:0] in_addr = '0;
   logic       in_wen = 1'b0;
   logic [3:0] in_fmask = '0;
   logic       wb_valid;
   logic       wb_ready = 1'b0;
   logic       wb_we;
   logic [2:0] wb_addr;
   logic [7:0] wb_data;
   logic [3:0] flags;
   logic [1:0] count;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];

   alu_writeback_stage #(.DATA_W(8), .ADDR_W(3), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_y(in_y), .in_c(in_c), .in_v(in_v), .in_n(in_n), .in_z(in_z),
      .in_addr(in_addr), .in_wen(in_wen), .in_fmask(in_fmask),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_we(wb_we),
      .wb_addr(wb_addr), .wb_data(wb_data), .flags(flags), .count(count)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- vector record ----------------
   typedef struct {
      logic       v;
      logic [7:0] y;
      logic [3:0] f;      // {c,v,n,z}
      logic [2:0] addr;
      logic       wen;
      logic [3:0] fm;
      logic       rdy;
      logic [1:0] e_cnt;
      logic       e_inr;
      logic       e_wbv;
      logic       e_we;
      logic [2:0] e_addr;
      logic [7:0] e_data;
      logic [3:0] e_flags;
   } vec_t;

   vec_t vecs[18];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input logic v, input logic [7:0] y, input logic [3:0] f,
                        input logic [2:0] addr, input logic wen, input logic [3:0] fm,
                        input logic rdy);
      in_valid = v;
      in_y     = y;
      {in_c, in_v, in_n, in_z} = f;
      in_addr  = addr;
      in_wen   = wen;
      in_fmask = fm;
      wb_ready = rdy;
   endtask

   task automatic idle();
      drive(1'b0, 8'h00, 4'h0, 3'd0, 1'b0, FMASK_NONE, 1'b0);
   endtask

   // ---------------- protocol invariants ----------------
   always @(negedge clk) begin
      check("count_le_depth", 32'(count <= 2'(DEPTH)), 32'd1);
      check("no_push_when_full", 32'(in_ready), 32'(count != 2'(DEPTH)));
      check("no_pop_when_empty", 32'(wb_valid), 32'(count != 2'd0));
      check("we_implies_valid", 32'(!wb_we || wb_valid), 32'd1);
   end

   // ---------------- main test ----------------
   initial begin
      // v   y      f      addr wen fm          rdy | cnt inr wbv we addr  data   flags
      vecs[0]  = '{1'b0, 8'h00, 4'h0, 3'd0, 1'b0, FMASK_NONE, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 4'b0000};
      vecs[1]  = '{1'b1, 8'h80, 4'b1010, 3'd5, 1'b1, FMASK_ALL, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 4'b0000};
      vecs[2]  = '{1'b0, 8'h00, 4'h0, 3'd0, 1'b0, FMASK_NONE, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 3'd5, 8'h80, 4'b0000};
      vecs[3]  = '{1'b0, 8'h00, 4'h0, 3'd0, 1'b0, FMASK_NONE, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 4'b1010};
      vecs[4]  = '{1'b1, 8'h11, 4'b0000, 3'd1, 1'b1, FMASK_ALL, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 4'b1010};
      vecs[5]  = '{1'b1, 8'h22, 4'b0100, 3'd2, 1'b1, FMASK_ALL, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 3'd1, 8'h11, 4'b1010};
      vecs[6]  = '{1'b1, 8'h33, 4'b0001, 3'd3, 1'b1, FMASK_ALL, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0, 3'd1, 8'h11, 4'b1010};
      vecs[7]  = '{1'b1, 8'h33, 4'b0001, 3'd3, 1'b1, FMASK_ALL, 1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 3'd1, 8'h11, 4'b1010};
      vecs[8]  = '{1'b1, 8'h33, 4'b0001, 3'd3, 1'b1, FMASK_ALL, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 3'd2, 8'h22, 4'b0000};
      vecs[9]  = '{1'b0, 8'h00, 4'h0, 3'd0, 1'b0, FMASK_NONE, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 3'd3, 8'h33, 4'b0100};
      vecs[10] = '{1'b0, 8'h00, 4'h0, 3'd0, 1'b0, FMASK_NONE, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 4'b0001};
      vecs[11] = '{1'b1, 8'hFF, 4'b1111, 3'd4, 1'b1, FMASK_ALL, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 4'b0001};
      vecs[12] = '{1'b1, 8'h00, 4'b0001, 3'd6, 1'b0, FMASK_NZ, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 3'd4, 8'hFF, 4'b0001};
      vecs[13] = '{1'b0, 8'h00, 4'h0, 3'd0, 1'b0, FMASK_NONE, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 3'd6, 8'h00, 4'b1111};
      vecs[14] = '{1'b0, 8'h00, 4'h0, 3'd0, 1'b0, FMASK_NONE, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 4'b1101};
      vecs[15] = '{1'b1, 8'h5A, 4'b1010, 3'd7, 1'b0, FMASK_NONE, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 4'b1101};
      vecs[16] = '{1'b0, 8'h00, 4'h0, 3'd0, 1'b0, FMASK_NONE, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 3'd7, 8'h5A, 4'b1101};
      vecs[17] = '{1'b0, 8'h00, 4'h0, 3'd0, 1'b0, FMASK_NONE, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 4'b1101};

      // Reset for two cycles, checked while still asserted and after release.
      idle();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_wb_valid", 32'(wb_valid), 32'd0);
      check("reset_wb_we", 32'(wb_we), 32'd0);
      check("reset_wb_addr", 32'(wb_addr), 32'd0);
      check("reset_wb_data", 32'(wb_data), 32'd0);
      rst_n = 1'b1;

      // Table: drive at the falling edge, check just after, state updates at the next rising edge.
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         drive(vecs[i].v, vecs[i].y, vecs[i].f, vecs[i].addr, vecs[i].wen, vecs[i].fm, vecs[i].rdy);
         #1;
         check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].e_cnt));
         check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_inr));
         check($sformatf("vec%0d_wb_valid", i), 32'(wb_valid), 32'(vecs[i].e_wbv));
         check($sformatf("vec%0d_wb_we", i), 32'(wb_we), 32'(vecs[i].e_we));
         check($sformatf("vec%0d_flags", i), 32'(flags), 32'(vecs[i].e_flags));
         if (vecs[i].e_wbv) begin
            check($sformatf("vec%0d_wb_addr", i), 32'(wb_addr), 32'(vecs[i].e_addr));
            check($sformatf("vec%0d_wb_data", i), 32'(wb_data), 32'(vecs[i].e_data));
         end
      end

      // Back-to-back push/pop at count=1 across pointer wrap; flags held via empty mask.
      @(negedge clk);
      drive(1'b1, 8'hA0, 4'b1111, 3'd1, 1'b1, FMASK_NONE, 1'b0);
      exp_q.push_back(8'hA0);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         drive(1'b1, 8'(8'hA0 + k), 4'b1111, 3'(k), 1'b1, FMASK_NONE, 1'b1);
         #1;
         check($sformatf("wrap%0d_count", k), 32'(count), 32'd1);
         check($sformatf("wrap%0d_wb_we", k), 32'(wb_we), 32'd1);
         check($sformatf("wrap%0d_wb_data", k), 32'(wb_data), 32'(exp_q.pop_front()));
         exp_q.push_back(8'(8'hA0 + k));
      end
      @(negedge clk);
      drive(1'b0, 8'h00, 4'h0, 3'd0, 1'b0, FMASK_NONE, 1'b1);
      #1;
      check("wrap_drain_data", 32'(wb_data), 32'(exp_q.pop_front()));
      check("wrap_drain_addr", 32'(wb_addr), 32'd6);
      @(negedge clk);
      idle();
      #1;
      check("wrap_empty_count", 32'(count), 32'd0);
      check("wrap_flags_held", 32'(flags), 32'b1101);

      // Fill to two entries, then assert reset asynchronously mid-cycle.
      @(negedge clk);
      drive(1'b1, 8'h44, 4'b1111, 3'd2, 1'b1, FMASK_ALL, 1'b0);
      @(negedge clk);
      drive(1'b1, 8'h55, 4'b1111, 3'd3, 1'b1, FMASK_ALL, 1'b0);
      @(negedge clk);
      idle();
      #1;
      check("prereset_count", 32'(count), 32'd2);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_rst_wb_valid", 32'(wb_valid), 32'd0);
      check("async_rst_count", 32'(count), 32'd0);
      check("async_rst_flags", 32'(flags), 32'd0);
      check("async_rst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      wb_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         check($sformatf("post_rst%0d_wb_valid", k), 32'(wb_valid), 32'd0);
         check($sformatf("post_rst%0d_wb_we", k), 32'(wb_we), 32'd0);
      end
      check("post_rst_flags", 32'(flags), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
